// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one unified Memory between the fetch port and the lw/sw data port
module memory_arbiter #(
    parameter int WRITE_HOLD     = 2,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        grant_d
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] READ     = 3'd1;
    localparam logic [2:0] WSETUP   = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] WRECOVER = 3'd4;
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam int HW = $clog2(WRITE_HOLD + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_DATA_BURST);
    localparam logic [HW-1:0] HMAX = HW'(WRITE_HOLD);

    logic [2:0]    state;
    logic [BW-1:0] burst;
    logic [HW-1:0] hold;
    logic          rd_d;
    logic          i_elig, d_elig, pick_d, pick_i;

    // a port that is completing this cycle is not eligible; data wins ties until its burst budget runs out
    always_comb begin
        i_elig = i_req && !i_ready;
        d_elig = d_req && !d_ready;
        pick_d = d_elig && (!i_elig || burst != BMAX);
        pick_i = i_elig && !pick_d;
    end

    // transaction sequencer; every Memory control line comes straight from a flop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            burst    <= '0;
            hold     <= '0;
            rd_d     <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
            grant_d  <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        grant_d  <= 1'b1;
                        mem_addr <= d_addr;
                        burst    <= !i_req ? '0 : (burst == BMAX ? BMAX : burst + 1'b1);
                        if (d_we) begin
                            mem_din <= d_wdata;
                            state   <= WSETUP;
                        end else begin
                            mem_ren <= 1'b1;
                            rd_d    <= 1'b1;
                            state   <= READ;
                        end
                    end else if (pick_i) begin
                        mem_addr <= i_addr;
                        mem_ren  <= 1'b1;
                        rd_d     <= 1'b0;
                        burst    <= '0;
                        state    <= READ;
                    end
                end
                READ: begin
                    mem_ren <= 1'b0;
                    grant_d <= 1'b0;
                    state   <= IDLE;
                    if (rd_d) begin
                        d_rdata <= mem_dout;
                        d_ready <= 1'b1;
                    end else begin
                        i_rdata <= mem_dout;
                        i_ready <= 1'b1;
                    end
                end
                WSETUP: begin
                    mem_wen <= 1'b1;
                    hold    <= HW'(1);
                    state   <= WRITE;
                end
                WRITE: begin
                    if (hold == HMAX) begin
                        mem_wen <= 1'b0;
                        state   <= WRECOVER;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                WRECOVER: begin
                    grant_d <= 1'b0;
                    d_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized scoreboard bench for memory_arbiter against a memory model and reference array
module tb_memory_arbiter;
    localparam int WH  = 2;
    localparam int MDB = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        grant_d;

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];
    ent_t        iq[$];
    ent_t        dq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          d_done = 0;
    int          wcyc = 0;
    int          lat, lat_f, lat_d, w0;

    memory_arbiter #(.WRITE_HOLD(WH), .MAX_DATA_BURST(MDB)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .grant_d(grant_d)
    );

    always #5 clock = ~clock;

    assign mem_dout = mem[mem_addr[15:2]];

    initial forever begin
        @(posedge clock);
        if (mem_wen) mem[mem_addr[15:2]] = mem_din;
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit all_zero();
        return !(mem_ren | mem_wen | i_ready | d_ready | grant_d) &&
               mem_addr == 0 && mem_din == 0 && i_rdata == 0 && d_rdata == 0;
    endfunction

    task automatic fetch(input logic [31:0] a, output int l);
        ent_t e;
        e.we = 1'b0; e.addr = a; e.data = ref_mem[a[15:2]];
        iq.push_back(e);
        i_req = 1'b1; i_addr = a; l = 0;
        do begin @(negedge clock); l++; end while (!i_ready && l < 200);
        if (!i_ready) chk(1'b0, "fetch_timeout", 32'(l), 32'd200);
        i_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd, output int l);
        ent_t e;
        e.we = we; e.addr = a; e.data = we ? wd : ref_mem[a[15:2]];
        if (we) ref_mem[a[15:2]] = wd;
        dq.push_back(e);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; l = 0;
        do begin @(negedge clock); l++; end while (!d_ready && l < 200);
        if (!d_ready) chk(1'b0, "data_timeout", 32'(l), 32'd200);
        d_req = 1'b0;
    endtask

    // monitor: protocol rules on Memory lines plus scoreboard pops on each ready pulse
    initial begin
        logic        prev_ren, prev_wen, prev_gd, stab_bad;
        logic [31:0] prev_addr, prev_din, wen_addr;
        int          rrun, wrun, wen_end;
        ent_t        e;
        prev_ren = 0; prev_wen = 0; prev_gd = 0; stab_bad = 0;
        prev_addr = 0; prev_din = 0; wen_addr = 0; rrun = 0; wrun = 0; wen_end = -10;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                prev_ren = 0; prev_wen = 0; prev_gd = 0; stab_bad = 0; rrun = 0; wrun = 0;
                prev_addr = mem_addr; prev_din = mem_din;
            end else begin
                if (mem_ren && mem_wen) chk(1'b0, "ren_wen_overlap", 32'd1, 32'd0);
                if ((mem_wen || prev_wen) && (mem_addr != prev_addr || mem_din != prev_din)) stab_bad = 1;
                if (mem_ren) rrun++;
                if (mem_wen) begin wrun++; wcyc++; end
                if (prev_ren && !mem_ren) begin
                    chk(rrun == 1, "ren_pulse_len", 32'(rrun), 32'd1);
                    rrun = 0;
                end
                if (prev_wen && !mem_wen) begin
                    chk(wrun == WH, "wen_pulse_len", 32'(wrun), 32'(WH));
                    chk(!stab_bad, "write_addr_din_stable", 32'(stab_bad), 32'd0);
                    wen_end = cyc; wen_addr = mem_addr; stab_bad = 0; wrun = 0;
                end
                if (i_ready) begin
                    if (iq.size() == 0) chk(1'b0, "unexpected_i_ready", 32'd1, 32'd0);
                    else begin
                        e = iq.pop_front();
                        chk(prev_ren && !prev_gd, "fetch_read_cycle", {30'd0, prev_ren, prev_gd}, 32'd2);
                        chk(prev_addr == e.addr, "fetch_mem_addr", prev_addr, e.addr);
                        chk(i_rdata == e.data, "fetch_rdata", i_rdata, e.data);
                    end
                end
                if (d_ready) begin
                    d_done++;
                    if (dq.size() == 0) chk(1'b0, "unexpected_d_ready", 32'd1, 32'd0);
                    else begin
                        e = dq.pop_front();
                        if (e.we) begin
                            chk(wen_end == cyc - 1, "store_ready_timing", 32'(cyc - wen_end), 32'd1);
                            chk(wen_addr == e.addr, "store_mem_addr", wen_addr, e.addr);
                            chk(mem[e.addr[15:2]] == e.data, "store_mem_content", mem[e.addr[15:2]], e.data);
                        end else begin
                            chk(prev_ren && prev_gd, "load_read_cycle", {30'd0, prev_ren, prev_gd}, 32'd3);
                            chk(prev_addr == e.addr, "load_mem_addr", prev_addr, e.addr);
                            chk(d_rdata == e.data, "load_rdata", d_rdata, e.data);
                        end
                    end
                end
                prev_ren = mem_ren; prev_wen = mem_wen; prev_gd = grant_d;
                prev_addr = mem_addr; prev_din = mem_din;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        repeat (3) @(negedge clock);
        chk(all_zero(), "reset_outputs_zero", mem_addr, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        w0 = wcyc;
        fetch(32'h10, lat);
        chk(lat == 2, "fetch_latency", 32'(lat), 32'd2);
        chk(i_rdata == 32'hDEADBEEF, "fetch_deadbeef", i_rdata, 32'hDEADBEEF);
        chk(wcyc == w0, "fetch_no_wen", 32'(wcyc - w0), 32'd0);

        @(negedge clock);
        data(1'b1, 32'h20, 32'h12345678, lat);
        chk(lat == WH + 3, "store_latency", 32'(lat), 32'(WH + 3));
        @(negedge clock);
        data(1'b0, 32'h20, 32'h0, lat);
        chk(lat == 2, "load_latency", 32'(lat), 32'd2);
        chk(d_rdata == 32'h12345678, "load_after_store", d_rdata, 32'h12345678);

        @(negedge clock);
        fork
            fetch(32'h4000, lat_f);
            data(1'b0, 32'h2004, 32'h0, lat_d);
            begin
                @(negedge clock);
                chk(grant_d && mem_ren, "simul_data_first", {30'd0, grant_d, mem_ren}, 32'd3);
                chk(mem_addr == 32'h2004, "simul_grant_addr", mem_addr, 32'h2004);
            end
        join
        chk(lat_d == 2, "simul_data_latency", 32'(lat_d), 32'd2);
        chk(lat_f == 4, "simul_fetch_latency", 32'(lat_f), 32'd4);

        @(negedge clock);
        fork
            begin
                int ls;
                for (int k = 0; k < 6; k++) data(1'b0, 32'h2000 + 32'(4 * k), 32'h0, ls);
            end
            begin
                int lf, d0;
                for (int k = 0; k < 2; k++) begin
                    d0 = d_done;
                    fetch(32'h4010 + 32'(4 * k), lf);
                    chk(d_done - d0 <= MDB, "fetch_wait_bound", 32'(d_done - d0), 32'(MDB));
                end
            end
        join

        @(negedge clock);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hA5A5A5A5;
        for (int n = 0; n < 20 && !mem_wen; n++) @(negedge clock);
        chk(mem_wen, "reset_test_reached_write", 32'(mem_wen), 32'd1);
        #2 reset = 1'b0;
        #1 chk(all_zero(), "async_reset_outputs_zero", {mem_din[15:0], 13'd0, mem_wen, d_ready, grant_d}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        fetch(32'h4008, lat);
        chk(lat == 2, "fetch_after_reset_latency", 32'(lat), 32'd2);

        @(negedge clock);
        fetch(32'h1004, lat);
        chk(lat == 2, "bit12_fetch_latency", 32'(lat), 32'd2);
        @(negedge clock);
        data(1'b1, 32'h1004, 32'hCAFEF00D, lat);
        chk(lat == WH + 3, "bit12_store_latency", 32'(lat), 32'(WH + 3));
        @(negedge clock);
        data(1'b0, 32'h1004, 32'h0, lat);
        chk(d_rdata == 32'hCAFEF00D, "bit12_load", d_rdata, 32'hCAFEF00D);

        @(negedge clock);
        fork
            begin
                int lr;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    data(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 31)), $urandom, lr);
                end
            end
            begin
                int lq;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    fetch(32'h4000 + 32'(4 * $urandom_range(0, 63)), lq);
                end
            end
        join
        repeat (5) @(negedge clock);
        chk(iq.size() == 0 && dq.size() == 0, "scoreboard_drained", 32'(iq.size() + dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
